// File: rtl/lza_normalizer.sv
// Leading-zero-anticipation normalizer: two-stage valid/ready pipeline that turns an adder magnitude
// plus LZA indicator into a normalized mantissa and exponent. Define LZA_NORM_CHECK_EN to add the LZA error checker.
module lza_normalizer #(
    parameter  int LEN   = 24,
    parameter  int EXP_W = 8,
    localparam int SHW   = $clog2(LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN-1:0]   in_mant,
    input  logic [LEN-1:0]   in_lza,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN-1:0]   out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic [SHW:0]     out_shamt,
    output logic             out_zero,
    output logic             out_denorm,
    output logic             out_lza_err
);

    // Common width for comparing the exponent against the shift count.
    localparam int CW = (EXP_W > SHW + 1) ? EXP_W : SHW + 1;

    // Zeros above the highest set bit; LEN when the vector is all zero.
    function automatic logic [SHW:0] lead_zeros(input logic [LEN-1:0] v);
        logic [SHW:0] n;
        logic         found;
        n     = (SHW+1)'(LEN);
        found = 1'b0;
        for (int i = LEN - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = (SHW+1)'(LEN - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    logic             s1_valid_q;
    logic [SHW-1:0]   s1_sc_q;
    logic [LEN-1:0]   s1_mant_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic             s1_zero_q;

    logic             s2_valid_q;
    logic [LEN-1:0]   out_mant_q;
    logic [EXP_W-1:0] out_exp_q;
    logic [SHW:0]     out_shamt_q;
    logic             out_zero_q;
    logic             out_denorm_q;

    logic             s1_adv;
    logic [SHW-1:0]   sc_d;

    logic [LEN-1:0]   tmp;
    logic             corr;
    logic [SHW:0]     s;
    logic [EXP_W-1:0] d_exp;
    logic [LEN-1:0]   out_mant_d;
    logic [EXP_W-1:0] out_exp_d;
    logic [SHW:0]     out_shamt_d;
    logic             out_zero_d;
    logic             out_denorm_d;

    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;

    always_comb begin
        sc_d = (in_lza == '0) ? SHW'(LEN - 1) : SHW'(lead_zeros(in_lza));
    end

    // The LZA may under-predict by one; the top bit of the trial shift tells us.
    always_comb begin
        tmp          = s1_mant_q << s1_sc_q;
        corr         = ~tmp[LEN-1];
        s            = {1'b0, s1_sc_q} + (SHW+1)'(corr);
        d_exp        = (s1_exp_q == '0) ? '0 : s1_exp_q - EXP_W'(1);
        out_mant_d   = '0;
        out_exp_d    = '0;
        out_shamt_d  = '0;
        out_zero_d   = 1'b0;
        out_denorm_d = 1'b0;
        if (s1_zero_q) begin
            out_zero_d = 1'b1;
        end else if (CW'(s1_exp_q) > CW'(s)) begin
            out_mant_d  = corr ? (tmp << 1) : tmp;
            out_exp_d   = s1_exp_q - EXP_W'(s);
            out_shamt_d = s;
        end else begin
            out_mant_d   = s1_mant_q << d_exp;
            out_shamt_d  = (SHW+1)'(d_exp);
            out_denorm_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sc_q    <= '0;
            s1_mant_q  <= '0;
            s1_exp_q   <= '0;
            s1_zero_q  <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sc_q   <= sc_d;
                s1_mant_q <= in_mant;
                s1_exp_q  <= in_exp;
                s1_zero_q <= (in_mant == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q   <= 1'b0;
            out_mant_q   <= '0;
            out_exp_q    <= '0;
            out_shamt_q  <= '0;
            out_zero_q   <= 1'b0;
            out_denorm_q <= 1'b0;
        end else if (s1_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_mant_q   <= out_mant_d;
                out_exp_q    <= out_exp_d;
                out_shamt_q  <= out_shamt_d;
                out_zero_q   <= out_zero_d;
                out_denorm_q <= out_denorm_d;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_mant   = out_mant_q;
    assign out_exp    = out_exp_q;
    assign out_shamt  = out_shamt_q;
    assign out_zero   = out_zero_q;
    assign out_denorm = out_denorm_q;

`ifdef LZA_NORM_CHECK_EN
    logic [SHW:0] s1_lzc_q;
    logic         out_lza_err_q;
    logic [SHW:0] sc_ext;
    logic         lza_err_d;

    // A correct prediction lands on the exact count or one short of it.
    always_comb begin
        sc_ext    = {1'b0, s1_sc_q};
        lza_err_d = !s1_zero_q && (s1_lzc_q != sc_ext) && (s1_lzc_q != sc_ext + (SHW+1)'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_lzc_q      <= '0;
            out_lza_err_q <= 1'b0;
        end else begin
            if (in_ready && in_valid) begin
                s1_lzc_q <= lead_zeros(in_mant);
            end
            if (s1_adv && s1_valid_q) begin
                out_lza_err_q <= lza_err_d;
            end
        end
    end

    assign out_lza_err = out_lza_err_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && out_valid && out_lza_err) begin
            $error("lza_normalizer: LZA prediction error, mant=%h shamt=%0d", out_mant, out_shamt);
        end
    end
`endif
`else
    assign out_lza_err = 1'b0;
`endif

endmodule

// File: doc/lza_normalizer.md
Name: lza_normalizer

Overview:
- Consumer end of the leading-zero-anticipation path in the FPU adder datapath.
- Takes an unnormalized adder magnitude plus the LZA indicator vector, which predicts the shift to within one position. Produces a normalized mantissa, an adjusted exponent, and status flags.
- Two-stage pipeline with valid/ready handshake; sits between the mantissa adder/LZA stage and rounding.

Parameters:
- LEN, 24: mantissa/indicator width in bits.
- EXP_W, 8: exponent width.
- SHW, $clog2(LEN): shift-amount width (derived; not overridden).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_mant  input  LEN  unnormalized magnitude, unsigned.
- in_lza  input  LEN  LZA indicator; the highest set bit marks the predicted leading one.
- in_exp  input  EXP_W  biased exponent before normalization.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_mant  output  LEN  normalized mantissa; MSB = 1 unless out_zero or out_denorm.
- out_exp  output  EXP_W  adjusted exponent.
- out_shamt  output  SHW+1  total left shift applied.
- out_zero  output  1  in_mant was zero.
- out_denorm  output  1  shift was clamped by the exponent; result is subnormal.
- out_lza_err  output  1  LZA prediction error flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Both stage valids clear.
  - All data registers clear, so out_mant=0, out_exp=0, out_shamt=0, all flags 0, out_valid=0.
  - in_ready=1 from the first cycle after reset release.
  - Reset mid-operation drops in-flight beats silently.
- Handshake:
  - s1_adv = !s2_valid | out_ready.
  - in_ready = !s1_valid | s1_adv.
  - A beat transfers on in_valid & in_ready; out is consumed on out_valid & out_ready.
  - No combinational path from in_valid to out_valid.
  - Full throughput of 1 beat/cycle when out_ready=1.
  - Latency is 2 cycles from input handshake to out_valid.
- Stage 1 (registered):
  - sc = number of zeros above the highest set bit of in_lza, i.e. LEN-1-pos.
  - If in_lza = 0, sc = LEN-1.
  - Also register in_mant, in_exp, and zero = (in_mant == 0).
- Stage 2 (registered outputs):
  - tmp = mant << sc.
  - corr = !tmp[LEN-1] (the LZA under-predicts by at most 1).
  - s = sc + corr, computed SHW+1 bits wide.
  - If zero: out_mant=0, out_exp=0, out_shamt=0, out_zero=1, out_denorm=0.
  - Else if in_exp > s: out_mant = corr ? tmp<<1 : tmp, out_exp = in_exp - s, out_shamt = s.
  - Else (clamp): d = (in_exp==0) ? 0 : in_exp-1; out_mant = mant << d, out_exp=0, out_shamt=d, out_denorm=1.
- Stall: while s2_valid & !out_ready, stage-2 and all outputs hold stable. Stage 1 holds if it is also valid.
- Boundaries:
  - If in_mant[LEN-1]=1 and in_lza has its top bit set: s=0, output equals input.
  - in_exp = s exactly takes the clamp path.

Optional Feature:
- Macro: LZA_NORM_CHECK_EN.
- Defined:
  - Stage 1 also computes the exact leading-zero count of in_mant.
  - Stage 2 sets out_lza_err=1 when the exact count is not equal to sc or sc+1, with mant nonzero.
  - The output path still uses the corr rule above.
  - A simulation-only $error fires on out_lza_err & out_valid.
- Not defined: out_lza_err is tied to 0 and no exact counter is synthesized.

Test Plan:
- Exact prediction: in_mant=24'h000F00, in_lza=24'h000800, in_exp=100 -> 2 cycles later out_mant=24'hF00000, out_exp=88, out_shamt=12, flags 0.
- Under-prediction correction: in_mant=24'h000F00, in_lza=24'h001000, in_exp=100 -> sc=11, corr=1, out_mant=24'hF00000, out_exp=88, out_shamt=12.
- Denormal clamp: in_mant=24'h000F00, in_lza=24'h000800, in_exp=5 -> out_mant=24'h00F000, out_exp=0, out_shamt=4, out_denorm=1. in_exp=0 -> out_mant=24'h000F00, out_shamt=0, out_denorm=1.
- Zero and no-shift:
  - in_mant=0, in_lza=0 -> out_zero=1, out_mant=0, out_exp=0.
  - in_mant=24'h800001, in_lza=24'h800000, in_exp=7 -> unchanged, out_shamt=0.
- Backpressure: stream 4 beats with out_ready=0 for 3 cycles after the first result -> in_ready=0 once both stages are full, outputs stable, all 4 results emerge in order with no loss or duplication. Then back-to-back streaming at 1/cycle with out_ready=1.
- Reset mid-flight: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately, outputs 0, no stale beat after release. With LZA_NORM_CHECK_EN: in_mant=24'h000F00, in_lza=24'h100000 -> out_lza_err=1.
